// File: rtl/mov_down_seq.sv
// 2048 "move down" engine: N_PASS compaction passes, one merge pass, N_PASS
// compaction passes. Optional win detection is built when MOV_DOWN_WIN_EN is defined.
module mov_down_seq #(
    parameter int WIN_EXP = 11,
    parameter int N_PASS  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [0:3][0:3][3:0]  grid_in,
    output logic [0:3][0:3][3:0]  grid_out,
    output logic                  busy,
    output logic                  done,
    output logic                  moved,
    output logic [3:0]            merge_cnt,
    output logic [2:0]            state_dbg
`ifdef MOV_DOWN_WIN_EN
    ,
    output logic                  win
`endif
);

    // Handshake: start is a level sampled on any rising edge while IDLE.
    // done is a one-cycle pulse; grid_out/moved/merge_cnt hold until the next done.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT1 = 3'd1,
        MERGE  = 3'd2,
        SHIFT2 = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [2:0] LAST_PASS = 3'(N_PASS - 1);

    state_t               state, state_next;
    logic [0:3][0:3][3:0] work, orig;
    logic [0:3][0:3][3:0] shift_grid, merge_grid;
    logic [2:0]           pass_cnt;
    logic [3:0]           merge_add;
    logic                 merge_win;

    function automatic logic [0:3][3:0] compact_col(input logic [0:3][3:0] g);
        logic [0:3][3:0] r;
        r = g;
        if (g[3] == 4'd0)      r = {4'd0, g[0], g[1], g[2]};
        else if (g[2] == 4'd0) r = {4'd0, g[0], g[1], g[3]};
        else if (g[1] == 4'd0) r = {4'd0, g[0], g[2], g[3]};
        return r;
    endfunction

    // Merged exponent saturates at 15 instead of wrapping.
    function automatic logic [3:0] inc_sat(input logic [3:0] x);
        return (x == 4'hf) ? 4'hf : x + 4'd1;
    endfunction

    always_comb begin
        shift_grid = work;
        merge_grid = work;
        merge_add  = 4'd0;
        merge_win  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            shift_grid[i] = compact_col(work[i]);
            if (work[i][3] == work[i][2] && work[i][3] != 4'd0) begin
                merge_grid[i][3] = inc_sat(work[i][3]);
                merge_grid[i][2] = 4'd0;
                merge_add        = merge_add + 4'd1;
                if (work[i][1] == work[i][0] && work[i][1] != 4'd0) begin
                    merge_grid[i][1] = inc_sat(work[i][1]);
                    merge_grid[i][0] = 4'd0;
                    merge_add        = merge_add + 4'd1;
                end
            end else if (work[i][2] == work[i][1] && work[i][2] != 4'd0) begin
                merge_grid[i][2] = inc_sat(work[i][2]);
                merge_grid[i][1] = 4'd0;
                merge_add        = merge_add + 4'd1;
            end else if (work[i][1] == work[i][0] && work[i][1] != 4'd0) begin
                merge_grid[i][1] = inc_sat(work[i][1]);
                merge_grid[i][0] = 4'd0;
                merge_add        = merge_add + 4'd1;
            end
            // Only tiles that changed in this pass can be new merge results.
            for (int j = 0; j < 4; j++) begin
                if (merge_grid[i][j] != work[i][j] && merge_grid[i][j] != 4'd0 &&
                    32'(merge_grid[i][j]) >= WIN_EXP)
                    merge_win = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT1;
            SHIFT1:  if (pass_cnt == LAST_PASS) state_next = MERGE;
            MERGE:   state_next = SHIFT2;
            SHIFT2:  if (pass_cnt == LAST_PASS) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            orig      <= '0;
            pass_cnt  <= 3'd0;
            grid_out  <= '0;
            moved     <= 1'b0;
            merge_cnt <= 4'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        work      <= grid_in;
                        orig      <= grid_in;
                        pass_cnt  <= 3'd0;
                        merge_cnt <= 4'd0;
                    end
                end
                SHIFT1: begin
                    work     <= shift_grid;
                    pass_cnt <= (pass_cnt == LAST_PASS) ? 3'd0 : pass_cnt + 3'd1;
                end
                MERGE: begin
                    work      <= merge_grid;
                    merge_cnt <= merge_cnt + merge_add;
                    pass_cnt  <= 3'd0;
                end
                SHIFT2: begin
                    work     <= shift_grid;
                    pass_cnt <= pass_cnt + 3'd1;
                    if (pass_cnt == LAST_PASS) begin
                        grid_out <= shift_grid;
                        moved    <= (shift_grid != orig);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MOV_DOWN_WIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        win <= 1'b0;
        else if (state == MERGE && merge_win) win <= 1'b1;
    end
`endif

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_mov_down_seq.sv
// Directed bench for mov_down_seq: driver pushes hand-computed results into a
// queue, a monitor pops and compares on every done pulse.
module tb_mov_down_seq;

  typedef logic [0:3][0:3][3:0] grid_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  grid_t       grid_in;
  grid_t       grid_out;
  logic        busy;
  logic        done;
  logic        moved;
  logic [3:0]  merge_cnt;
  logic [2:0]  state_dbg;
`ifdef MOV_DOWN_WIN_EN
  logic        win;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;
  int n_expect = 0;

  // {grid, moved, merge_cnt}
  logic [68:0] exp_q[$];

  mov_down_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .grid_in   (grid_in),
    .grid_out  (grid_out),
    .busy      (busy),
    .done      (done),
    .moved     (moved),
    .merge_cnt (merge_cnt),
    .state_dbg (state_dbg)
`ifdef MOV_DOWN_WIN_EN
    ,
    .win       (win)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic grid_t set_col(input grid_t base, input int c,
                                    input logic [3:0] a, input logic [3:0] b,
                                    input logic [3:0] d2, input logic [3:0] d3);
    grid_t g;
    g = base;
    g[c][0] = a;
    g[c][1] = b;
    g[c][2] = d2;
    g[c][3] = d3;
    return g;
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      logic [68:0] e;
      n_done++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done with empty queue expected none");
      end else begin
        e = exp_q.pop_front();
        chk("grid_out", grid_out, e[68:5]);
        chk("moved", 64'(moved), 64'(e[4]));
        chk("merge_cnt", 64'(merge_cnt), 64'(e[3:0]));
      end
    end
  end

  // driver tasks
  task automatic issue(input grid_t g);
    @(negedge clk);
    start   = 1'b1;
    grid_in = g;
    @(negedge clk);
    start   = 1'b0;
    grid_in = grid_t'({$urandom, $urandom});
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic run_move(input grid_t g, input grid_t eg, input logic em,
                          input logic [3:0] ec, input bit hammer);
    int cyc;
    exp_q.push_back({eg, em, ec});
    n_expect++;
    issue(g);
    if (hammer) begin
      start   = 1'b1;
      grid_in = set_col('0, 1, 4'd3, 4'd3, 4'd3, 4'd3);
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", 64'(cyc), 64'd7);
    if (done === 1'b1) begin
      @(negedge clk);
      start = 1'b0;
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("grid_out_hold", grid_out, eg);
    end
    repeat (3) @(negedge clk);
  endtask

  grid_t g, eg;

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    grid_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_grid_out", grid_out, '0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_moved", 64'(moved), 64'd0);
    chk("rst_merge_cnt", 64'(merge_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // double merge in one column
    g  = set_col('0, 0, 4'd1, 4'd1, 4'd2, 4'd2);
    eg = set_col('0, 0, 4'd0, 4'd0, 4'd2, 4'd3);
    run_move(g, eg, 1'b1, 4'd2, 1'b0);

    // bottom-priority merge, merged tile does not merge again
    g  = set_col('0, 0, 4'd2, 4'd2, 4'd2, 4'd0);
    eg = set_col('0, 0, 4'd0, 4'd0, 4'd2, 4'd3);
    run_move(g, eg, 1'b1, 4'd1, 1'b0);

    // no change possible
    g = '0;
    for (int c = 0; c < 4; c++) g = set_col(g, c, 4'd1, 4'd2, 4'd3, 4'd4);
    run_move(g, g, 1'b0, 4'd0, 1'b0);

    // saturation at 15, start hammered while busy and during DONE
    g  = set_col('0, 0, 4'd0, 4'd0, 4'd15, 4'd15);
    eg = set_col('0, 0, 4'd0, 4'd0, 4'd0, 4'd15);
    run_move(g, eg, 1'b1, 4'd1, 1'b1);
    repeat (12) @(negedge clk);

    // several columns at once
    g  = set_col('0, 1, 4'd4, 4'd0, 4'd4, 4'd0);
    g  = set_col(g, 2, 4'd3, 4'd3, 4'd3, 4'd3);
    g  = set_col(g, 3, 4'd5, 4'd0, 4'd0, 4'd0);
    eg = set_col('0, 1, 4'd0, 4'd0, 4'd0, 4'd5);
    eg = set_col(eg, 2, 4'd0, 4'd0, 4'd4, 4'd4);
    eg = set_col(eg, 3, 4'd0, 4'd0, 4'd0, 4'd5);
    run_move(g, eg, 1'b1, 4'd3, 1'b0);

    // mid-move reset: abort, no done pulse, outputs cleared
    issue(set_col('0, 0, 4'd1, 4'd1, 4'd2, 4'd2));
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_grid_out", grid_out, '0);
    chk("abort_merge_cnt", 64'(merge_cnt), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    g  = set_col('0, 0, 4'd1, 4'd1, 4'd2, 4'd2);
    eg = set_col('0, 0, 4'd0, 4'd0, 4'd2, 4'd3);
    run_move(g, eg, 1'b1, 4'd2, 1'b0);

`ifdef MOV_DOWN_WIN_EN
    chk("win_clear", 64'(win), 64'd0);
    g  = set_col('0, 0, 4'd0, 4'd0, 4'd10, 4'd10);
    eg = set_col('0, 0, 4'd0, 4'd0, 4'd0, 4'd11);
    run_move(g, eg, 1'b1, 4'd1, 1'b0);
    chk("win_set", 64'(win), 64'd1);
    g = '0;
    for (int c = 0; c < 4; c++) g = set_col(g, c, 4'd1, 4'd2, 4'd3, 4'd4);
    run_move(g, g, 1'b0, 4'd0, 1'b0);
    chk("win_sticky", 64'(win), 64'd1);
`endif

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("done_count", 64'(n_done), 64'(n_expect));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mov_down_seq.md
Name: mov_down_seq

Overview:
Sequential 2048-style "move down" engine, the downward counterpart of the existing upward move logic. Accepts a 4x4 grid of 4-bit tile exponents on a start pulse and runs the full move in fixed time:
- compaction passes, then
- one merge pass, then
- compaction passes again.

Returns the result with a done pulse, a moved flag and a merge count. Sits between the game-control FSM (which issues start when the down key is pressed) and the grid register/VGA renderer.

Parameters:
- WIN_EXP, 11: tile exponent that counts as a win (2^11 = 2048); used only with the optional feature.
- N_PASS, 3: compaction passes before and after the merge; 3 is sufficient for a 4-cell column. Legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a move; sampled only in IDLE
- grid_in  in  4x[0:3][0:3]  grid [column i][row j]; j=0 top, j=3 bottom; value 0 = empty, n = tile 2^n
- grid_out  out  4x[0:3][0:3]  result grid, registered
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; grid_out, moved and merge_cnt are valid from this cycle onward
- moved  out  1  result differs from the sampled grid_in
- merge_cnt  out  4  number of merges performed in this move (0..8)
- win  out  1  present only with MOV_DOWN_WIN_EN

Behaviour:
- One clock and one reset. Reset is asynchronous and active-low: rst_n low forces state IDLE and clears the work grid, pass counter, grid_out, busy, done, moved, merge_cnt and win.
- States:
  - IDLE
  - SHIFT1
  - MERGE
  - SHIFT2
  - DONE
- IDLE: on an edge with start=1, latch grid_in into both the work grid and the orig copy, clear the pass counter, go to SHIFT1.
- SHIFT1: apply one compaction pass to every column per edge. After N_PASS passes go to MERGE.
- Compaction pass, per column i, checked bottom-up:
  - if g[3]==0: (g0,g1,g2,g3) <- (0,g0,g1,g2)
  - elif g[2]==0: <- (0,g0,g1,g3)
  - elif g[1]==0: <- (0,g0,g2,g3)
  - else unchanged
- MERGE: one edge, all columns in parallel. Exactly one of these rules applies per column:
  - if g3==g2!=0: g3<=g3+1, g2<=0; additionally, if g1==g0!=0, g1<=g1+1, g0<=0.
  - elif g2==g1!=0: g2<=g2+1, g1<=0.
  - elif g1==g0!=0: g1<=g1+1, g0<=0.
  - else no change.
  - Each merge increments merge_cnt. A merge of exponent 15 saturates at 15 (no wrap).
  - Then go to SHIFT2 with the pass counter cleared.
- SHIFT2: N_PASS compaction passes, then go to DONE. On the edge entering DONE, register:
  - grid_out <= work grid
  - moved <= (work grid != orig)
- DONE: done=1 for exactly this one cycle, then IDLE on the next edge.
- Latency: with start sampled at edge k, DONE is entered at edge k+2*N_PASS+1 (k+7 at default).
- start while busy, or during DONE: ignored. No queueing.
- grid_out, moved and merge_cnt hold their values until the next DONE. merge_cnt clears when a new start is accepted.
- grid_in may change freely after the start edge.
- rst_n asserted mid-move: immediate abort to IDLE, all outputs 0. No done pulse is produced for the aborted move.

Optional Feature:
- Macro: MOV_DOWN_WIN_EN.
- Defined:
  - win port exists.
  - win sets when any MERGE result equals WIN_EXP or more.
  - win is sticky until rst_n.
- Undefined:
  - win port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Column 0 = (j0..j3) (1,1,2,2), other columns 0, start -> done at edge k+7 with column 0 = (0,0,2,3), merge_cnt=2, moved=1.
- Column 0 = (2,2,2,0) -> (0,0,2,3), merge_cnt=1. Checks bottom-priority merge and that a merged tile does not merge again.
- All columns (1,2,3,4) -> grid_out == grid_in, moved=0, merge_cnt=0.
- Column 0 = (0,0,15,15) -> (0,0,0,15), merge_cnt=1 (saturation). Also assert start while busy -> ignored, exactly one done pulse.
- Pull rst_n low at edge k+3 mid-move -> busy=0, done never pulses, grid_out=0. Then a new start completes normally.
- With MOV_DOWN_WIN_EN and WIN_EXP=11: column (0,0,10,10) -> (0,0,0,11), win=1, and win stays 1 across a following non-winning move.
